// File: rtl/act_pkg.sv
// ----------------------------------------------------------------------------
// act_pkg
//   Shared definitions for the activity monitor: the mount reset-pulse FSM
//   state type, the default parameter values used by act_monitor/act_chan,
//   and a helper that sizes saturating counters.
//
//   Optional feature macro used by the monitor: ACT_BLINK_EN (blinking LED).
// ----------------------------------------------------------------------------
package act_pkg;

  // Default parameter values (clk_sys cycles where applicable).
  localparam int unsigned NCH_DEF        = 2;
  localparam int unsigned TIMEOUT_DEF    = 1000000;
  localparam int unsigned RST_CYCLES_DEF = 10000000;
  localparam int unsigned BLINK_DIV_DEF  = 4000000;

  // Mount reset-pulse state machine: IDLE drives rst_img low, HOLD drives it
  // high for the configured number of cycles.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } mount_state_e;

  // Bits needed for a counter that must be able to hold the value max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage : act_pkg

// File: rtl/act_chan.sv
// ----------------------------------------------------------------------------
// act_chan
//   One activity-monitor channel. A toggle is the monitored line differing
//   from its value one cycle earlier while the channel is enabled. Each
//   toggle restarts a saturating hold counter; the registered activity flag
//   stays high for exactly TIMEOUT cycles after the most recent toggle.
//
// Parameters
//   TIMEOUT  activity hold time in clk_sys cycles (>= 1)
//
// Ports
//   clk_sys  in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   sig_i    in   monitored line, synchronous to clk_sys
//   en_i     in   channel enable; toggles are ignored while low
//   act_o    out  registered activity flag
// ----------------------------------------------------------------------------
module act_chan
  import act_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic sig_i,
  input  logic en_i,
  output logic act_o
);

  localparam int unsigned   CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  logic          hist_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_q, act_d;
  logic          toggle;

  // The history register tracks the line even while disabled, so re-enabling
  // a channel never reports a stale edge.
  assign toggle = en_i & (sig_i ^ hist_q);

  // NOTE: every combinational output gets a default assignment first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    cnt_d = cnt_q;
    if (toggle) begin
      // A toggle wins over expiry in the same cycle: the hold restarts and
      // the flag never drops.
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Counter value k after the edge means k cycles have elapsed since the
    // toggle cycle+1; the flag is high while fewer than TIMEOUT have.
    act_d = (cnt_d != CNT_MAX);
  end

  // NOTE: the counter resets to its saturated value, not zero, so the channel
  // comes out of reset quiet instead of flashing activity for TIMEOUT cycles.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= 1'b0;
      cnt_q  <= CNT_MAX;
      act_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      hist_q <= sig_i;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
    end
  end

  assign act_o = act_q;

endmodule : act_chan

// File: rtl/act_monitor.sv
// ----------------------------------------------------------------------------
// act_monitor
//   Activity monitor for NCH serial lines plus an image-mount helper.
//   - Per channel (act_chan): activity flag held TIMEOUT cycles after the last
//     qualified toggle of the line.
//   - led: OR of all activity flags. With ACT_BLINK_EN defined, led instead
//     blinks with a half-period of BLINK_DIV cycles while any channel is
//     active, starting high, and is low when all channels are idle.
//   - Mount helper: a one-cycle mount_stb latches img_nonzero into vsd_sel and
//     raises rst_img for RST_CYCLES cycles; a strobe during the pulse restarts
//     the full count and reloads vsd_sel.
//
// Configuration macro: ACT_BLINK_EN (undefined -> steady LED, no blink logic)
//
// Parameters
//   NCH         number of monitored channels (1..8)
//   TIMEOUT     activity hold time in cycles (>= 1)
//   RST_CYCLES  rst_img pulse length in cycles (>= 1)
//   BLINK_DIV   LED blink half-period in cycles (>= 1), ACT_BLINK_EN only
//
// Ports
//   clk_sys      in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   sig          in   [NCH] monitored lines, synchronous to clk_sys
//   ch_en        in   [NCH] per-channel enable
//   mount_stb    in   one-cycle image-mounted strobe
//   img_nonzero  in   mounted image size non-zero, sampled on mount_stb
//   act          out  [NCH] per-channel activity flags
//   led          out  combined activity LED
//   vsd_sel      out  virtual-SD select latched at mount
//   rst_img      out  reset request after mount
// ----------------------------------------------------------------------------
module act_monitor
  import act_pkg::*;
#(
  parameter int unsigned NCH        = NCH_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
  parameter int unsigned BLINK_DIV  = BLINK_DIV_DEF
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  input  logic [NCH-1:0] sig,
  input  logic [NCH-1:0] ch_en,
  input  logic           mount_stb,
  input  logic           img_nonzero,
  output logic [NCH-1:0] act,
  output logic           led,
  output logic           vsd_sel,
  output logic           rst_img
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // --------------------------------------------------------------------------
  if (NCH == 0 || NCH > 8) begin : g_bad_nch
    $error("act_monitor: NCH must be in 1..8");
  end
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("act_monitor: TIMEOUT must be >= 1");
  end
  if (RST_CYCLES == 0) begin : g_bad_rst_cycles
    $error("act_monitor: RST_CYCLES must be >= 1");
  end
  if (BLINK_DIV == 0) begin : g_bad_blink_div
    $error("act_monitor: BLINK_DIV must be >= 1");
  end

  // --------------------------------------------------------------------------
  // Activity channels
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    act_chan #(
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .sig_i   (sig[i]),
      .en_i    (ch_en[i]),
      .act_o   (act[i])
    );
  end

  logic act_any;
  assign act_any = |act;

  // --------------------------------------------------------------------------
  // LED
  // --------------------------------------------------------------------------
`ifdef ACT_BLINK_EN
  // Phase counter runs over one full blink period while any channel is
  // active; the first half of the period (starting at 0) drives the LED high.
  localparam int unsigned   BW         = cnt_width(2 * BLINK_DIV - 1);
  localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;

  always_comb begin
    blink_cnt_d = '0;
    if (act_any) begin
      blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
    end
  end

  // The counter is 0 in every idle cycle, so the first active cycle is high.
  assign led = act_any & (blink_cnt_q < BLINK_HALF);
`else
  assign led = act_any;
`endif

  // --------------------------------------------------------------------------
  // Mount reset-pulse FSM
  // --------------------------------------------------------------------------
  localparam int unsigned    RCW     = cnt_width(RST_CYCLES);
  localparam logic [RCW-1:0] RST_MAX = RCW'(RST_CYCLES);

  mount_state_e   state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;     // cycles of rst_img high so far (HOLD)
  logic           vsd_q, vsd_d;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    vsd_d   = vsd_q;
    if (mount_stb) begin
      // A strobe enters or re-enters HOLD with the full pulse length, also
      // when a pulse is already running.
      state_d = HOLD;
      rcnt_d  = RCW'(1);
      vsd_d   = img_nonzero;
    end else begin
      case (state_q)
        HOLD: begin
          if (rcnt_q == RST_MAX) begin
            state_d = IDLE;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RCW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      vsd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      vsd_q   <= vsd_d;
    end
  end

  assign rst_img = (state_q == HOLD);
  assign vsd_sel = vsd_q;

endmodule : act_monitor
